// File: rtl/pipeline_pkg.sv
// Shared types and per-channel arithmetic for the layer mixer.
// The PIPELINE_MIXER_ALPHA_EN build uses blend565; the default build uses avg565.
package pipeline_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_CHROMA = 2'd1,
    MODE_DIRECT = 2'd2,
    MODE_BLEND  = 2'd3
  } overlay_mode_e;

  localparam int R_W     = 5;
  localparam int G_W     = 6;
  localparam int B_W     = 5;
  localparam int PIX_W   = R_W + G_W + B_W;
  localparam int ALPHA_W = 4;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  // Truncating 50% mix; each channel is summed separately so nothing carries across fields.
  function automatic rgb565_t avg565(rgb565_t acc, rgb565_t fg);
    logic [R_W:0] r;
    logic [G_W:0] g;
    logic [B_W:0] b;
    r = {1'b0, acc.r} + {1'b0, fg.r};
    g = {1'b0, acc.g} + {1'b0, fg.g};
    b = {1'b0, acc.b} + {1'b0, fg.b};
    avg565.r = r[R_W:1];
    avg565.g = g[G_W:1];
    avg565.b = b[B_W:1];
  endfunction

  function automatic logic [G_W-1:0] blend_ch(logic [G_W-1:0] cf, logic [G_W-1:0] cb,
                                              logic [ALPHA_W-1:0] a);
    logic [9:0] p;
    p = 10'(cf) * 10'(a) + 10'(cb) * (10'd16 - 10'(a));
    return p[9:4];
  endfunction

  function automatic rgb565_t blend565(rgb565_t fg, rgb565_t acc, logic [ALPHA_W-1:0] a);
    logic [G_W-1:0] r;
    logic [G_W-1:0] b;
    r = blend_ch({1'b0, fg.r}, {1'b0, acc.r}, a);
    b = blend_ch({1'b0, fg.b}, {1'b0, acc.b}, a);
    blend565.r = r[R_W-1:0];
    blend565.g = blend_ch(fg.g, acc.g, a);
    blend565.b = b[B_W-1:0];
  endfunction

endpackage

// File: rtl/pipeline_layer_stage.sv
// One compositing stage: folds layer LAYER into the accumulated pixel and forwards all lanes.
// Mode 3 is an alpha blend when PIPELINE_MIXER_ALPHA_EN is defined, else a 50% average.
module pipeline_layer_stage
  import pipeline_pkg::*;
#(
  parameter int          PRECISION  = 12,
  parameter int          NUM_LAYERS = 2,
  parameter int          LAYER      = 0,
  parameter logic [15:0] CHROMA_KEY = 16'h07E0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vld_p0,
  input  logic                          en_p0,
  input  logic                          app_p0,
  input  logic [PRECISION-1:0]          x_p0,
  input  logic [PRECISION-1:0]          y_p0,
  input  logic [PIX_W-1:0]              acc_p0,
  input  logic [PIX_W*NUM_LAYERS-1:0]   fg_p0,
  input  logic [NUM_LAYERS-1:0]         skip_p0,
  input  logic [2*NUM_LAYERS-1:0]       mode_p0,
  input  logic [ALPHA_W*NUM_LAYERS-1:0] alpha_p0,
  output logic                          vld_p1,
  output logic                          en_p1,
  output logic                          app_p1,
  output logic [PRECISION-1:0]          x_p1,
  output logic [PRECISION-1:0]          y_p1,
  output logic [PIX_W-1:0]              acc_p1,
  output logic [PIX_W*NUM_LAYERS-1:0]   fg_p1,
  output logic [NUM_LAYERS-1:0]         skip_p1,
  output logic [2*NUM_LAYERS-1:0]       mode_p1,
  output logic [ALPHA_W*NUM_LAYERS-1:0] alpha_p1
);

  logic [PIX_W-1:0] fg;
  overlay_mode_e    mode;
  logic [PIX_W-1:0] acc_next;

  assign fg   = fg_p0[PIX_W*LAYER +: PIX_W];
  assign mode = overlay_mode_e'(mode_p0[2*LAYER +: 2]);

  always_comb begin
    acc_next = acc_p0;
    if (!skip_p0[LAYER]) begin
      case (mode)
        MODE_CHROMA: if (fg != CHROMA_KEY) acc_next = fg;
        MODE_DIRECT: acc_next = fg;
`ifdef PIPELINE_MIXER_ALPHA_EN
        MODE_BLEND:  acc_next = blend565(fg, acc_p0, alpha_p0[ALPHA_W*LAYER +: ALPHA_W]);
`else
        MODE_BLEND:  acc_next = avg565(acc_p0, fg);
`endif
        default:     acc_next = acc_p0;
      endcase
    end
  end

  // ---- stage boundary: p0 -> p1 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      en_p1    <= 1'b0;
      app_p1   <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      acc_p1   <= '0;
      fg_p1    <= '0;
      skip_p1  <= '0;
      mode_p1  <= '0;
      alpha_p1 <= '0;
    end else begin
      vld_p1   <= vld_p0;
      en_p1    <= en_p0;
      app_p1   <= app_p0;
      x_p1     <= x_p0;
      y_p1     <= y_p0;
      acc_p1   <= acc_next;
      fg_p1    <= fg_p0;
      skip_p1  <= skip_p0;
      mode_p1  <= mode_p0;
      alpha_p1 <= alpha_p0;
    end
  end

endmodule

// File: rtl/pipeline_layer_mixer.sv
// Background + NUM_LAYERS foreground compositor, latency NUM_LAYERS+1, frame-synchronous controls.
// Define PIPELINE_MIXER_ALPHA_EN to add ctrl_alpha and turn mode 3 into an alpha blend.
module pipeline_layer_mixer
  import pipeline_pkg::*;
#(
  parameter int          PRECISION  = 12,
  parameter int          NUM_LAYERS = 2,
  parameter logic [15:0] CHROMA_KEY = 16'h07E0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [PRECISION-1:0]          pixel_x,
  input  logic [PRECISION-1:0]          pixel_y,
  input  logic                          output_enable,
  input  logic [15:0]                   bg_pixel_in,
  input  logic [16*NUM_LAYERS-1:0]      fg_pixel_in,
  input  logic [NUM_LAYERS-1:0]         fg_pixel_skip,
  input  logic [2*NUM_LAYERS-1:0]       ctrl_overlay_mode,
`ifdef PIPELINE_MIXER_ALPHA_EN
  input  logic [4*NUM_LAYERS-1:0]       ctrl_alpha,
`endif
  output logic                          out_valid,
  output logic [15:0]                   pixel_out,
  output logic [PRECISION-1:0]          pixel_x_out,
  output logic [PRECISION-1:0]          pixel_y_out,
  output logic                          ctrl_applied
);

  localparam int N = NUM_LAYERS;

  logic                          load;
  logic [2*N-1:0]                shadow_mode;
  logic [2*N-1:0]                mode_eff;
  logic [ALPHA_W*N-1:0]          alpha_eff;

  // A (0,0) beat both reloads the shadows and uses the new values itself.
  assign load     = in_valid && (pixel_x == '0) && (pixel_y == '0);
  assign mode_eff = load ? ctrl_overlay_mode : shadow_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_mode <= '0;
    else if (load) shadow_mode <= ctrl_overlay_mode;
  end

`ifdef PIPELINE_MIXER_ALPHA_EN
  logic [ALPHA_W*N-1:0] shadow_alpha;
  assign alpha_eff = load ? ctrl_alpha : shadow_alpha;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_alpha <= '0;
    else if (load) shadow_alpha <= ctrl_alpha;
  end
`else
  assign alpha_eff = '0;
`endif

  logic                 vld_p0, en_p0, app_p0;
  logic [PRECISION-1:0] x_p0, y_p0;
  logic [PIX_W-1:0]     bg_p0;
  logic [PIX_W*N-1:0]   fg_p0;
  logic [N-1:0]         skip_p0;
  logic [2*N-1:0]       mode_p0;
  logic [ALPHA_W*N-1:0] alpha_p0;

  // ---- stage 0: input register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      en_p0  <= 1'b0;
      app_p0 <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      en_p0  <= output_enable;
      app_p0 <= load;
    end
  end

  always_ff @(posedge clk) begin
    x_p0     <= pixel_x;
    y_p0     <= pixel_y;
    bg_p0    <= bg_pixel_in;
    fg_p0    <= fg_pixel_in;
    skip_p0  <= fg_pixel_skip;
    mode_p0  <= mode_eff;
    alpha_p0 <= alpha_eff;
  end

  logic                 vld_s   [N+1];
  logic                 en_s    [N+1];
  logic                 app_s   [N+1];
  logic [PRECISION-1:0] x_s     [N+1];
  logic [PRECISION-1:0] y_s     [N+1];
  logic [PIX_W-1:0]     acc_s   [N+1];
  logic [PIX_W*N-1:0]   fg_s    [N+1];
  logic [N-1:0]         skip_s  [N+1];
  logic [2*N-1:0]       mode_s  [N+1];
  logic [ALPHA_W*N-1:0] alpha_s [N+1];

  assign vld_s[0]   = vld_p0;
  assign en_s[0]    = en_p0;
  assign app_s[0]   = app_p0;
  assign x_s[0]     = x_p0;
  assign y_s[0]     = y_p0;
  assign acc_s[0]   = bg_p0;
  assign fg_s[0]    = fg_p0;
  assign skip_s[0]  = skip_p0;
  assign mode_s[0]  = mode_p0;
  assign alpha_s[0] = alpha_p0;

  // ---- stages 1..N: layer k-1 composited in stage k ----
  for (genvar k = 0; k < N; k++) begin : g_layer
    pipeline_layer_stage #(
      .PRECISION  (PRECISION),
      .NUM_LAYERS (N),
      .LAYER      (k),
      .CHROMA_KEY (CHROMA_KEY)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_p0   (vld_s[k]),
      .en_p0    (en_s[k]),
      .app_p0   (app_s[k]),
      .x_p0     (x_s[k]),
      .y_p0     (y_s[k]),
      .acc_p0   (acc_s[k]),
      .fg_p0    (fg_s[k]),
      .skip_p0  (skip_s[k]),
      .mode_p0  (mode_s[k]),
      .alpha_p0 (alpha_s[k]),
      .vld_p1   (vld_s[k+1]),
      .en_p1    (en_s[k+1]),
      .app_p1   (app_s[k+1]),
      .x_p1     (x_s[k+1]),
      .y_p1     (y_s[k+1]),
      .acc_p1   (acc_s[k+1]),
      .fg_p1    (fg_s[k+1]),
      .skip_p1  (skip_s[k+1]),
      .mode_p1  (mode_s[k+1]),
      .alpha_p1 (alpha_s[k+1])
    );
  end

  assign out_valid    = vld_s[N];
  assign pixel_out    = en_s[N] ? acc_s[N] : 16'h0000;
  assign pixel_x_out  = x_s[N];
  assign pixel_y_out  = y_s[N];
  assign ctrl_applied = vld_s[N] & app_s[N];

  // Lanes past the last stage have no consumer.
  logic unused_lanes;
  assign unused_lanes = ^{fg_s[N], skip_s[N], mode_s[N], alpha_s[N]};

endmodule

// File: doc/pipeline_layer_mixer.md
Name: pipeline_layer_mixer

Overview:
- Parametrised successor to the single-foreground pipeline wrapper.
- Composites a background plus NUM_LAYERS foreground layers (RGB565) in a fixed-latency pipeline, one stage per layer.
- Each layer has its own overlay mode and skip flag.
- Sits after the SRAM foreground fetch; its output drives the VGA output timing stage.

Parameters:
PRECISION, 12, width of pixel_x/pixel_y
NUM_LAYERS, 2, number of foreground layers (1..4); layer 0 is bottom-most
CHROMA_KEY, 16'h07E0, RGB565 key colour treated as transparent in chroma mode

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
pixel_x  in  PRECISION  input pixel column
pixel_y  in  PRECISION  input pixel row
output_enable  in  1  0 = blanking
bg_pixel_in  in  16  background pixel
fg_pixel_in  in  16*NUM_LAYERS  layer k at bits [16k+15:16k], aligned with bg
fg_pixel_skip  in  NUM_LAYERS  1 = layer k has no pixel here (outside its window)
ctrl_overlay_mode  in  2*NUM_LAYERS  per layer: 0 off, 1 chroma key, 2 direct, 3 blend
ctrl_alpha  in  4*NUM_LAYERS  per-layer alpha; only present with PIPELINE_MIXER_ALPHA_EN
out_valid  out  1  output beat valid
pixel_out  out  16  composited pixel
pixel_x_out  out  PRECISION  delayed pixel_x
pixel_y_out  out  PRECISION  delayed pixel_y
ctrl_applied  out  1  one-cycle pulse when the shadow controls were reloaded

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all pipeline valids 0, shadow modes 0 (all layers off), shadow alpha 0.
- Latency: fixed NUM_LAYERS+1 cycles from an in_valid beat to out_valid.
  - Stage 0 registers inputs.
  - Stage k (1..NUM_LAYERS) composites layer k-1 over the accumulated pixel.
  - Fully pipelined: one beat per cycle; bubbles (in_valid=0) propagate as out_valid=0.
- Per-layer fg pixel and skip are delayed alongside the accumulator so layer k is consumed in stage k+1.
- Control shadowing (frame-synchronous, no mid-frame tearing):
  - Shadow regs load ctrl_overlay_mode/ctrl_alpha when in_valid && pixel_x==0 && pixel_y==0.
  - The new values apply to that same beat.
  - ctrl_applied pulses in the same cycle as that beat's out_valid.
  - At all other times, control input changes are ignored.
- Layer composite, per stage (acc = accumulated pixel, fg = layer pixel):
  - skip=1 or mode 0: acc unchanged.
  - mode 1: acc = (fg==CHROMA_KEY) ? acc : fg.
  - mode 2: acc = fg.
  - mode 3, without the feature: per-channel average, R=(Ra+Rf)>>1, G=(Ga+Gf)>>1, B=(Ba+Bf)>>1; truncating, no carry across channels.
- Blanking:
  - If the delayed output_enable=0, pixel_out=16'h0000; coordinates and out_valid still propagate.
- Boundary rules:
  - All layers skipped gives pixel_out = bg.
  - Higher layer index always wins over lower.
  - Reset mid-frame: shadow modes return to 0 until the next (0,0) beat; in-flight beats are discarded.
  - (0,0) with in_valid=0 does not reload.

Optional Feature:
- Macro: PIPELINE_MIXER_ALPHA_EN.
- Defined:
  - ctrl_alpha port exists.
  - Mode 3 = alpha blend per channel: c = (cf*a + cb*(16-a))>>4, where a = shadow alpha (0..15) and intermediates are 10 bits wide.
  - a=0 yields acc unchanged.
  - Blend is pipelined inside the same stage; latency unchanged.
- Undefined:
  - Port absent.
  - Mode 3 = 50% average.

Decomposition:
- Shared package pipeline_pkg:
  - overlay mode constants (MODE_OFF, MODE_CHROMA, MODE_DIRECT, MODE_BLEND).
  - RGB565 field widths/offsets.
  - rgb565 pixel typedef.
  - average/blend functions.
- Sub-module pipeline_layer_stage: one compositing stage holding acc, valid, enable, coordinates, and the remaining delayed fg lanes. Generated NUM_LAYERS times.

Test Plan:
- Reset, then stream a frame with bg=16'h1234, fg0=16'hFFFF, modes left 0 -> every pixel_out=16'h1234, out_valid exactly 3 cycles after in_valid (NUM_LAYERS=2).
- Layer 0 mode 1 at (0,0), fg0 alternating 16'h07E0/16'hF800 over bg 16'h001F -> outputs alternate 16'h001F/16'hF800; ctrl_applied pulses once.
- Layer 0 mode 2 fg0=16'hF800, layer 1 mode 2 fg1=16'h001F, fg_pixel_skip=2'b10 on odd pixels -> even pixels 16'h001F, odd pixels 16'hF800.
- Mode 3 without macro, bg=16'h0000, fg=16'hFFFF -> 16'h7BEF; with macro and alpha=8 -> 16'h7BEF, alpha=0 -> 16'h0000.
- Change ctrl_overlay_mode mid-frame at (100,50) -> no effect until next (0,0) beat; output_enable=0 beats -> pixel_out=0 with coordinates preserved.
- Assert rst_n=0 mid-frame for 1 cycle -> out_valid=0 and outputs 0 immediately; after release the output is bg-only until the next (0,0).
